fclk_align: RTL and testbench

Parametrised frame-clock aligner for multi-lane ADC LVDS receivers. It sits after the per-lane deserialisers in the divided-clock domain. Deserialiser bitslip is replaced by a word-level barrel shift, which works for any deserialisation ratio. It finds the bit offset at which the deserialised frame clock matches a programmable frame pattern, applies the same offset to NCHAN data lanes, declares lock after a run of consecutive matches, and re-searches automatically on sustained loss of frame.

---
 rtl/fclk_align_pkg.sv | 17 +
 rtl/fclk_lane_shift.sv | 35 +++
 rtl/fclk_align.sv | 167 ++++++++++++++++
 tb/tb_fclk_align.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fclk_align_pkg.sv
// rtl/fclk_align_pkg.sv - shared types, widths and helpers for the frame-clock aligner
package fclk_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERRCNT_WIDTH = 16;

    // Offset register width; never narrower than one bit.
    function automatic int slip_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fclk_lane_shift.sv
// rtl/fclk_lane_shift.sv - per-lane previous-word register and word-level barrel shift
module fclk_lane_shift
    import fclk_align_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int SW         = slip_width(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] cur,
    input  logic [SW-1:0]         s,
    output logic [WORD_WIDTH-1:0] window
);

    logic [WORD_WIDTH-1:0]   prev;
    logic [2*WORD_WIDTH-1:0] shifted;

    // Keep the previous valid word; a realignment request empties it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev <= '0;
        end else if (load) begin
            prev <= cur;
        end
    end

    // s=0 selects prev; larger s pulls the earliest bits of cur in at the top.
    always_comb begin
        shifted = {cur, prev} >> s;
        window  = shifted[WORD_WIDTH-1:0];
    end

endmodule

// File: rtl/fclk_align.sv
// rtl/fclk_align.sv - frame-clock aligner top; define FCLK_ALIGN_ERRCNT_EN to build the error counter
module fclk_align
    import fclk_align_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 8,
    parameter int                    NCHAN         = 4,
    parameter logic [WORD_WIDTH-1:0] FRAME_PATTERN = WORD_WIDTH'(8'hF0),
    parameter int                    LOCK_COUNT    = 4,
    parameter int                    UNLOCK_COUNT  = 2,
    parameter int                    SW            = slip_width(WORD_WIDTH)
) (
    input  logic                        lclk,
    input  logic                        rst,
    input  logic [WORD_WIDTH-1:0]       fclk_word,
    input  logic                        fclk_valid,
    input  logic [NCHAN*WORD_WIDTH-1:0] data_in,
    input  logic                        align_req,
    output logic [NCHAN*WORD_WIDTH-1:0] data_out,
    output logic                        data_valid,
    output logic                        locked,
    output logic [SW-1:0]               slip_count,
    output logic [ERRCNT_WIDTH-1:0]     err_count
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);

    state_t                      state, state_n;
    logic [SW-1:0]               slip, slip_n, slip_adv;
    logic [7:0]                  match_cnt, match_n;
    logic [7:0]                  miss_cnt, miss_n;
    logic [WORD_WIDTH-1:0]       fclk_win;
    logic [NCHAN*WORD_WIDTH-1:0] data_win;
    logic                        load;
    logic                        hit;

    // A word that coincides with a realignment request is discarded.
    assign load     = fclk_valid && !align_req;
    assign hit      = (fclk_win == FRAME_PATTERN);
    assign slip_adv = (slip == SW'(WORD_WIDTH - 1)) ? '0 : slip + SW'(1);

    fclk_lane_shift #(.WORD_WIDTH(WORD_WIDTH), .SW(SW)) u_fclk_lane (
        .clk    (lclk),
        .rst    (rst),
        .clear  (align_req),
        .load   (load),
        .cur    (fclk_word),
        .s      (slip),
        .window (fclk_win)
    );

    for (genvar k = 0; k < NCHAN; k++) begin : g_lane
        fclk_lane_shift #(.WORD_WIDTH(WORD_WIDTH), .SW(SW)) u_data_lane (
            .clk    (lclk),
            .rst    (rst),
            .clear  (align_req),
            .load   (load),
            .cur    (data_in[k*WORD_WIDTH +: WORD_WIDTH]),
            .s      (slip),
            .window (data_win[k*WORD_WIDTH +: WORD_WIDTH])
        );
    end

    // FSM and counter registers; realignment request restarts the search at offset 0.
    always_ff @(posedge lclk) begin
        if (rst || align_req) begin
            state     <= SEARCH;
            slip      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_n;
            slip      <= slip_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
        end
    end

    // Next state: only valid words move the search, verification and loss-of-frame counters.
    always_comb begin
        state_n = state;
        slip_n  = slip;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        if (fclk_valid) begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        match_n = 8'd1;
                        miss_n  = '0;
                        state_n = (LOCK_N == 8'd1) ? LOCKED : VERIFY;
                    end else begin
                        slip_n = slip_adv;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        match_n = match_cnt + 8'd1;
                        miss_n  = '0;
                        if (match_n == LOCK_N) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        slip_n  = slip_adv;
                        match_n = '0;
                        state_n = SEARCH;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        miss_n = '0;
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                        if (miss_n == UNLOCK_N) begin
                            state_n = SEARCH;
                            slip_n  = slip_adv;
                            miss_n  = '0;
                            match_n = '0;
                        end
                    end
                end
                default: begin
                    state_n = SEARCH;
                end
            endcase
        end
    end

    // Aligned data registered from the valid-cycle window; valid only if still locked after the edge.
    always_ff @(posedge lclk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (align_req) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= fclk_valid && (state_n == LOCKED);
            if (fclk_valid) begin
                data_out <= data_win;
            end
        end
    end

    assign locked     = (state == LOCKED);
    assign slip_count = slip;

`ifdef FCLK_ALIGN_ERRCNT_EN
    logic                    err_inc;
    logic [ERRCNT_WIDTH-1:0] err_q;

    assign err_inc = fclk_valid && (state == LOCKED) && !hit;

    // Saturating count of frames that failed to match while locked.
    always_ff @(posedge lclk) begin
        if (rst || align_req) begin
            err_q <= '0;
        end else if (err_inc && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fclk_align.sv
// tb/tb_fclk_align.sv - directed self-checking bench for fclk_align
module tb_fclk_align;

    localparam int W     = 8;
    localparam int NCHAN = 4;
`ifdef FCLK_ALIGN_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 lclk = 1'b0;
    logic                 rst;
    logic [W-1:0]         fclk_word;
    logic                 fclk_valid;
    logic [NCHAN*W-1:0]   data_in;
    logic                 align_req;
    logic [NCHAN*W-1:0]   data_out;
    logic                 data_valid;
    logic                 locked;
    logic [2:0]           slip_count;
    logic [15:0]          err_count;

    int n_assert = 0;
    int n_fail   = 0;
    int t;
    int d;
    int cor_a = -100;
    int cor_b = -100;

    always #5 lclk = ~lclk;

    fclk_align #(
        .WORD_WIDTH    (W),
        .NCHAN         (NCHAN),
        .FRAME_PATTERN (8'hF0),
        .LOCK_COUNT    (4),
        .UNLOCK_COUNT  (2)
    ) dut (
        .lclk       (lclk),
        .rst        (rst),
        .fclk_word  (fclk_word),
        .fclk_valid (fclk_valid),
        .data_in    (data_in),
        .align_req  (align_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .slip_count (slip_count),
        .err_count  (err_count)
    );

    // Aligned frame f of a lane: lane 0 is the frame clock, lane k+1 carries k+0x10+f.
    function automatic logic [7:0] frame_val(input int lane, input int f);
        if (lane == 0) begin
            return (f >= cor_a && f <= cor_b) ? 8'h0F : 8'hF0;
        end
        return 8'(lane + 15 + f);
    endfunction

    // Deserialised word t of a lane whose serial stream is delayed by d bits.
    function automatic logic [7:0] word_at(input int lane, input int tt);
        logic [7:0] w;
        logic [7:0] fv;
        int m;
        for (int i = 0; i < 8; i++) begin
            m    = 8 * tt + i - d;
            fv   = frame_val(lane, m / 8);
            w[i] = fv[m % 8];
        end
        return w;
    endfunction

    // Expected data_out after consuming word t-1 at the correct offset: frame t-2.
    function automatic logic [31:0] exp_data();
        logic [31:0] e;
        for (int k = 0; k < NCHAN; k++) begin
            e[k*8 +: 8] = 8'(k + 16 + t - 2);
        end
        return e;
    endfunction

    task automatic step(input bit v, input bit ar = 1'b0);
        align_req  = ar;
        fclk_valid = v;
        if (v) begin
            fclk_word = word_at(0, t);
            for (int k = 0; k < NCHAN; k++) begin
                data_in[k*8 +: 8] = word_at(k + 1, t);
            end
        end else begin
            fclk_word = 8'($urandom);
            data_in   = $urandom;
        end
        @(posedge lclk);
        #1;
        if (v) t++;
        align_req  = 1'b0;
        fclk_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_err(input int n);
        return ERR_EN ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst        = 1'b1;
        align_req  = 1'b0;
        fclk_valid = 1'b0;
        fclk_word  = '0;
        data_in    = '0;
        repeat (2) @(posedge lclk);
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_slip", 32'(slip_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Stream delayed by 3 bits: three misses, then four matches.
        d = 3;
        t = 1;
        step(1);
        chk("a_slip1", 32'(slip_count), 32'd1);
        step(1);
        step(1);
        chk("a_slip3", 32'(slip_count), 32'd3);
        chk("a_unlocked3", 32'(locked), 32'd0);
        step(1);
        step(1);
        step(1);
        chk("a_unlocked6", 32'(locked), 32'd0);
        chk("a_dv6", 32'(data_valid), 32'd0);
        step(1);
        chk("a_locked7", 32'(locked), 32'd1);
        chk("a_dv7", 32'(data_valid), 32'd1);
        chk("a_slip7", 32'(slip_count), 32'd3);
        chk("a_data7", data_out, exp_data());
        step(1);
        chk("a_data8", data_out, exp_data());

        // Single corrupted frame, then two consecutive ones.
        cor_a = t - 1;
        cor_b = t - 1;
        step(1);
        chk("b_err1", 32'(err_count), exp_err(1));
        chk("b_locked1", 32'(locked), 32'd1);
        chk("b_dv1", 32'(data_valid), 32'd1);
        step(1);
        chk("b_locked2", 32'(locked), 32'd1);
        cor_a = t - 1;
        cor_b = t;
        step(1);
        chk("b_err2", 32'(err_count), exp_err(2));
        chk("b_locked3", 32'(locked), 32'd1);
        step(1);
        chk("b_unlock", 32'(locked), 32'd0);
        chk("b_unlock_dv", 32'(data_valid), 32'd0);
        chk("b_slip4", 32'(slip_count), 32'd4);
        chk("b_err3", 32'(err_count), exp_err(3));
        repeat (7) step(1);
        chk("b_slip_back3", 32'(slip_count), 32'd3);
        repeat (3) step(1);
        chk("b_relock_pending", 32'(locked), 32'd0);
        step(1);
        chk("b_relocked", 32'(locked), 32'd1);
        chk("b_relock_data", data_out, exp_data());

        // Realignment request while locked at offset 3, then relock with gappy valid.
        step(1, 1);
        chk("c_locked0", 32'(locked), 32'd0);
        chk("c_slip0", 32'(slip_count), 32'd0);
        chk("c_err0", 32'(err_count), 32'd0);
        chk("c_dv0", 32'(data_valid), 32'd0);
        repeat (3) step(1);
        chk("c_slip3", 32'(slip_count), 32'd3);
        step(1);
        chk("c_dv_m1", 32'(data_valid), 32'd0);
        step(0);
        chk("c_dv_gap1", 32'(data_valid), 32'd0);
        step(1);
        step(0);
        chk("c_dv_gap2", 32'(data_valid), 32'd0);
        step(1);
        step(0);
        chk("c_locked_m3", 32'(locked), 32'd0);
        chk("c_dv_gap3", 32'(data_valid), 32'd0);
        chk("c_slip_hold", 32'(slip_count), 32'd3);
        step(1);
        chk("c_locked_m4", 32'(locked), 32'd1);
        chk("c_dv_m4", 32'(data_valid), 32'd1);
        chk("c_data_m4", data_out, exp_data());
        step(0);
        chk("c_dv_gap4", 32'(data_valid), 32'd0);
        chk("c_locked_gap4", 32'(locked), 32'd1);

        // Reset in the middle of verification.
        step(1, 1);
        repeat (5) step(1);
        chk("d_verify_slip", 32'(slip_count), 32'd3);
        rst = 1'b1;
        @(posedge lclk);
        #1;
        rst = 1'b0;
        chk("d_rst_data_out", data_out, 32'h0);
        chk("d_rst_dv", 32'(data_valid), 32'd0);
        chk("d_rst_locked", 32'(locked), 32'd0);
        chk("d_rst_slip", 32'(slip_count), 32'd0);
        chk("d_rst_err", 32'(err_count), 32'd0);

        // Offset 7: search to the top, lock, unlock wraps the offset to 0, relock at 7.
        d = 7;
        t = 1;
        cor_a = -100;
        cor_b = -100;
        repeat (7) step(1);
        chk("e_slip7", 32'(slip_count), 32'd7);
        chk("e_unlocked", 32'(locked), 32'd0);
        repeat (3) step(1);
        chk("e_unlocked_m3", 32'(locked), 32'd0);
        step(1);
        chk("e_locked", 32'(locked), 32'd1);
        chk("e_data", data_out, exp_data());
        cor_a = t - 1;
        cor_b = t;
        step(1);
        step(1);
        chk("e_unlock", 32'(locked), 32'd0);
        chk("e_slip_wrap", 32'(slip_count), 32'd0);
        chk("e_err2", 32'(err_count), exp_err(2));
        repeat (7) step(1);
        chk("e_slip7_again", 32'(slip_count), 32'd7);
        repeat (4) step(1);
        chk("e_relocked", 32'(locked), 32'd1);
        chk("e_relock_data", data_out, exp_data());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
